// File: rtl/snake_video_render_if.sv
// Bundle between the snake map producer and the video renderer: the map/flag
// capture side plus the timed video outputs headed for the TMDS encoder.
interface snake_video_render_if;
  logic [255:0] map_i;
  logic         map_valid_i;
  logic         game_over_i;
  logic         hsync_o;
  logic         vsync_o;
  logic         de_o;
  logic [23:0]  rgb_o;
  logic         frame_start_o;
  logic         pending_o;

  // Producer / video sink side
  modport master (
    output map_i,
    output map_valid_i,
    output game_over_i,
    input  hsync_o,
    input  vsync_o,
    input  de_o,
    input  rgb_o,
    input  frame_start_o,
    input  pending_o
  );

  // Renderer side
  modport slave (
    input  map_i,
    input  map_valid_i,
    input  game_over_i,
    output hsync_o,
    output vsync_o,
    output de_o,
    output rgb_o,
    output frame_start_o,
    output pending_o
  );
endinterface

// File: rtl/snake_video_render.sv
// Snake video renderer: latches 16x16 snake bitmaps from the map-read stage,
// swaps them in only at frame boundaries, and produces timed RGB video with a
// 2-clock pipeline from the h/v counters to every output.
module snake_video_render #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned MAP_X0     = 192,
  parameter int unsigned MAP_Y0     = 112
) (
  input  logic                 clk,
  input  logic                 rst,
  snake_video_render_if.slave  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned MAP_W   = 16 << CELL_SHIFT;

  localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActEnd  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] XLo      = HW'(MAP_X0);
  localparam logic [HW-1:0] XRing0   = HW'(MAP_X0 - 1);
  localparam logic [HW-1:0] XRing1   = HW'(MAP_X0 + MAP_W);

  localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActEnd  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] YLo      = VW'(MAP_Y0);
  localparam logic [VW-1:0] YRing0   = VW'(MAP_Y0 - 1);
  localparam logic [VW-1:0] YRing1   = VW'(MAP_Y0 + MAP_W);

  localparam logic [23:0] ColWhite = 24'hFFFFFF;
  localparam logic [23:0] ColGreen = 24'h00FF00;
  localparam logic [23:0] ColRed   = 24'hFF0000;
  localparam logic [23:0] ColGrey  = 24'h202020;

  // Timing counters
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          frame_end;

  // Map storage
  logic [255:0] shadow_q, active_q;
  logic         shadow_go_q, active_go_q, pending_q;

  // Stage 1
  logic [HW-1:0] hx, col_w;
  logic [VW-1:0] vy, row_w;
  logic          s1_de_d, s1_hsync_d, s1_vsync_d, s1_fs_d, s1_in_map_d, s1_border_d;
  logic [7:0]    s1_idx_d;
  logic          s1_de_q, s1_hsync_q, s1_vsync_q, s1_fs_q, s1_in_map_q, s1_border_q;
  logic [7:0]    s1_idx_q;

  // Stage 2
  logic          pix_bit;
  logic [23:0]   rgb_d, rgb_q;
  logic          hsync_q, vsync_q, de_q, fs_q;

  // Next-state of the raster counters; v advances when h wraps
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VW'(1);
    end
  end

  assign frame_end = (h_cnt_q == HLast) && (v_cnt_q == VLast);

  // Raster counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Capture into the shadow; promote to active only on the last counter position
  // of a frame, so a frame is always drawn from a single map. The promotion uses
  // the pre-capture shadow, so a same-cycle capture waits for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= '0;
      shadow_go_q <= 1'b0;
      active_q    <= '0;
      active_go_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      if (bus.map_valid_i) begin
        shadow_q    <= bus.map_i;
        shadow_go_q <= bus.game_over_i;
      end
      if (frame_end && pending_q) begin
        active_q    <= shadow_q;
        active_go_q <= shadow_go_q;
      end
      if (bus.map_valid_i) begin
        pending_q <= 1'b1;
      end else if (frame_end) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Stage 1 decode: active/sync windows, map membership, cell index, border ring
  always_comb begin
    hx    = h_cnt_q - XLo;
    vy    = v_cnt_q - YLo;
    col_w = hx >> CELL_SHIFT;
    row_w = vy >> CELL_SHIFT;

    s1_de_d    = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
    s1_hsync_d = !((h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd));
    s1_vsync_d = !((v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd));
    s1_fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Cell coordinate below 16 is the same as being left of the far map edge
    s1_in_map_d = (h_cnt_q >= XLo) && (v_cnt_q >= YLo) &&
                  (col_w[HW-1:4] == '0) && (row_w[VW-1:4] == '0);
    s1_idx_d    = {row_w[3:0], col_w[3:0]};

    s1_border_d = (((h_cnt_q == XRing0) || (h_cnt_q == XRing1)) &&
                   (v_cnt_q >= YRing0) && (v_cnt_q <= YRing1)) ||
                  (((v_cnt_q == YRing0) || (v_cnt_q == YRing1)) &&
                   (h_cnt_q >= XRing0) && (h_cnt_q <= XRing1));
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_de_q     <= 1'b0;
      s1_hsync_q  <= 1'b1;
      s1_vsync_q  <= 1'b1;
      s1_fs_q     <= 1'b0;
      s1_in_map_q <= 1'b0;
      s1_border_q <= 1'b0;
      s1_idx_q    <= '0;
    end else begin
      s1_de_q     <= s1_de_d;
      s1_hsync_q  <= s1_hsync_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_fs_q     <= s1_fs_d;
      s1_in_map_q <= s1_in_map_d;
      s1_border_q <= s1_border_d;
      s1_idx_q    <= s1_idx_d;
    end
  end

  // Stage 2 colour select: border over map cell over background
  always_comb begin
    pix_bit = active_q[s1_idx_q];
    rgb_d   = '0;
    if (s1_de_q) begin
      if (s1_border_q) begin
        rgb_d = ColWhite;
      end else if (s1_in_map_q) begin
        if (pix_bit) begin
          rgb_d = active_go_q ? ColRed : ColGreen;
        end else begin
          rgb_d = ColGrey;
        end
      end
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= s1_hsync_q;
      vsync_q <= s1_vsync_q;
      de_q    <= s1_de_q;
      fs_q    <= s1_fs_q;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.hsync_o       = hsync_q;
  assign bus.vsync_o       = vsync_q;
  assign bus.de_o          = de_q;
  assign bus.rgb_o         = rgb_q;
  assign bus.frame_start_o = fs_q;
  assign bus.pending_o     = pending_q;

endmodule

// File: tb/tb_snake_video_render.sv
// Directed bench for snake_video_render. A reduced-timing instance (80x55 total,
// 2 px cells, map at (16,8)) covers multi-frame behaviour; a default-parameter
// instance covers the full-size line timing of the first line.
module tb_snake_video_render;

  localparam int unsigned HT = 80;
  localparam int unsigned VT = 55;
  localparam int unsigned FR = HT * VT;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREY  = 24'h202020;
  localparam logic [23:0] BLACK = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc;
  int checks = 0;
  int errors = 0;
  logic [255:0] m;

  always #5 clk = ~clk;

  snake_video_render_if bus ();
  snake_video_render_if big ();

  snake_video_render #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CELL_SHIFT(1), .MAP_X0(16), .MAP_Y0(8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  snake_video_render u_big (
    .clk (clk),
    .rst (rst),
    .bus (big)
  );

  // Edges since reset release; output pixel index p is visible after edge p+2
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pix(input int unsigned f, input int unsigned x,
                                      input int unsigned y);
    return f * FR + y * HT + x;
  endfunction

  task automatic wait_idx(input int unsigned idx);
    while (cyc < idx + 2) begin
      @(posedge clk);
      #1;
    end
    if (cyc != idx + 2) begin
      errors++;
      $error("FAIL sched: idx %0d reached at cyc %0d", idx, cyc);
    end
  endtask

  task automatic px(input string tag, input int unsigned f, input int unsigned x,
                    input int unsigned y, input logic [23:0] exp);
    wait_idx(pix(f, x, y));
    chk24(tag, bus.rgb_o, exp);
  endtask

  task automatic pulse(input logic [255:0] mv, input logic go);
    bus.map_i       = mv;
    bus.game_over_i = go;
    bus.map_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.map_valid_i = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.map_i = '0; bus.map_valid_i = 1'b0; bus.game_over_i = 1'b0;
    big.map_i = '0; big.map_valid_i = 1'b0; big.game_over_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_hsync", bus.hsync_o, 1'b1);
    chk1("rst_vsync", bus.vsync_o, 1'b1);
    chk1("rst_de", bus.de_o, 1'b0);
    chk24("rst_rgb", bus.rgb_o, BLACK);
    chk1("rst_fs", bus.frame_start_o, 1'b0);
    chk1("rst_pending", bus.pending_o, 1'b0);
    chk1("rst_big_vsync", big.vsync_o, 1'b1);

    // T1: first pixel appears two edges after release
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk1("t1_de_edge1", bus.de_o, 1'b0);
    chk1("t1_fs_edge1", bus.frame_start_o, 1'b0);
    @(posedge clk); #1;
    chk1("t1_de_edge2", bus.de_o, 1'b1);
    chk1("t1_fs_edge2", bus.frame_start_o, 1'b1);
    chk1("t1_big_de", big.de_o, 1'b1);
    chk1("t1_big_fs", big.frame_start_o, 1'b1);
    wait_idx(1);  chk1("t1_fs_px1", bus.frame_start_o, 1'b0);
    wait_idx(67); chk1("t1_hs_67", bus.hsync_o, 1'b1);
    wait_idx(68); chk1("t1_hs_68", bus.hsync_o, 1'b0);
    wait_idx(75); chk1("t1_hs_75", bus.hsync_o, 1'b0);
    wait_idx(76); chk1("t1_hs_76", bus.hsync_o, 1'b1);

    // T2: capture mid-frame 0; frame 0 keeps the empty map
    wait_idx(pix(0, 20, 6));
    m = '0; m[0] = 1'b1;
    pulse(m, 1'b0);
    chk1("t2_pending_set", bus.pending_o, 1'b1);
    wait_idx(639); chk1("t1_big_de_639", big.de_o, 1'b1);
    wait_idx(640); chk1("t1_big_de_640", big.de_o, 1'b0);
    wait_idx(655); chk1("t1_big_hs_655", big.hsync_o, 1'b1);
    wait_idx(656);
    chk1("t1_big_hs_656", big.hsync_o, 1'b0);
    chk24("t2_f0_16_8", bus.rgb_o, GREY);
    px("t2_f0_17_9", 0, 17, 9, GREY);
    wait_idx(751); chk1("t1_big_hs_751", big.hsync_o, 1'b0);
    wait_idx(752); chk1("t1_big_hs_752", big.hsync_o, 1'b1);
    wait_idx(pix(0, 0, 49));  chk1("t1_vs_49", bus.vsync_o, 1'b1);
    wait_idx(pix(0, 0, 50));  chk1("t1_vs_50", bus.vsync_o, 1'b0);
    wait_idx(pix(0, 79, 51)); chk1("t1_vs_51", bus.vsync_o, 1'b0);
    wait_idx(pix(0, 0, 52));  chk1("t1_vs_52", bus.vsync_o, 1'b1);
    wait_idx(FR - 3); chk1("t2_pending_before", bus.pending_o, 1'b1);
    wait_idx(FR - 2); chk1("t2_pending_after", bus.pending_o, 1'b0);

    // T2/T3: frame 1 shows cell (0,0) and the border ring
    px("t3_ring_15_7", 1, 15, 7, WHITE);
    px("t3_out_14_8", 1, 14, 8, BLACK);
    px("t3_ring_15_8", 1, 15, 8, WHITE);
    px("t2_f1_16_8", 1, 16, 8, GREEN);
    px("t2_f1_18_8", 1, 18, 8, GREY);
    px("t2_f1_17_9", 1, 17, 9, GREEN);
    px("t3_ring_48_20", 1, 48, 20, WHITE);
    px("t3_blank_64_20", 1, 64, 20, BLACK);
    chk1("t3_blank_de", bus.de_o, 1'b0);
    px("t3_f1_47_39", 1, 47, 39, GREY);
    px("t3_ring_16_40", 1, 16, 40, WHITE);

    // T4: game-over map with cells (0,0), (1,2), (15,15)
    wait_idx(pix(1, 0, 45));
    m = '0; m[0] = 1'b1; m[18] = 1'b1; m[255] = 1'b1;
    pulse(m, 1'b1);
    px("t4_ring_15_8", 2, 15, 8, WHITE);
    px("t4_16_8", 2, 16, 8, RED);
    px("t4_18_8", 2, 18, 8, GREY);
    px("t4_19_10", 2, 19, 10, GREY);
    px("t4_20_10", 2, 20, 10, RED);
    px("t4_45_39", 2, 45, 39, GREY);
    px("t4_46_39", 2, 46, 39, RED);
    px("t4_47_39", 2, 47, 39, RED);

    // T5: A then B in frame 2, B wins in frame 3
    wait_idx(pix(2, 0, 41));
    m = '0; m[0] = 1'b1;
    pulse(m, 1'b0);
    wait_idx(pix(2, 0, 43));
    m = '0; m[1] = 1'b1;
    pulse(m, 1'b0);
    px("t5_f3_16_8", 3, 16, 8, GREY);
    px("t5_f3_18_8", 3, 18, 8, GREEN);

    // T5: D mid frame 3, C on the boundary cycle; D in frame 4, C in frame 5
    wait_idx(pix(3, 0, 41));
    m = '0; m[3] = 1'b1;
    pulse(m, 1'b0);
    wait_idx(4 * FR - 3);
    m = '0; m[2] = 1'b1;
    pulse(m, 1'b0);
    chk1("t5_pending_kept", bus.pending_o, 1'b1);
    wait_idx(4 * FR + 100); chk1("t5_pending_f4", bus.pending_o, 1'b1);
    px("t5_f4_20_8", 4, 20, 8, GREY);
    px("t5_f4_22_8", 4, 22, 8, GREEN);
    wait_idx(5 * FR - 3); chk1("t5_pending_end4", bus.pending_o, 1'b1);
    wait_idx(5 * FR - 2); chk1("t5_pending_clr", bus.pending_o, 1'b0);
    px("t5_f5_20_8", 5, 20, 8, GREEN);
    px("t5_f5_22_8", 5, 22, 8, GREY);

    // T6: capture then reset mid-line
    wait_idx(pix(5, 30, 11));
    pulse('1, 1'b1);
    chk1("t6_pending_pre", bus.pending_o, 1'b1);
    chk1("t6_de_pre", bus.de_o, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t6_hsync", bus.hsync_o, 1'b1);
    chk1("t6_vsync", bus.vsync_o, 1'b1);
    chk1("t6_de", bus.de_o, 1'b0);
    chk24("t6_rgb", bus.rgb_o, BLACK);
    chk1("t6_fs", bus.frame_start_o, 1'b0);
    chk1("t6_pending", bus.pending_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    wait_idx(0);
    chk1("t6_fs_restart", bus.frame_start_o, 1'b1);
    chk1("t6_de_restart", bus.de_o, 1'b1);
    px("t6_f0_16_8", 0, 16, 8, GREY);
    px("t6_f0_20_8", 0, 20, 8, GREY);
    wait_idx(700); chk1("t6_pending_f0", bus.pending_o, 1'b0);
    px("t6_f0_47_39", 0, 47, 39, GREY);
    px("t6_f1_16_8", 1, 16, 8, GREY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
